// File: rtl/pcm_to_i2s_pkg.sv
// pcm_to_i2s_pkg: shared defaults, frame-counter sizing and the transmitter
// arming state for the I2S output stage.
package pcm_to_i2s_pkg;

    // Default PCM word width and bit clocks per ws half-period.
    localparam int DEF_NUMBER_OF_BITS = 8;
    localparam int DEF_SLOT_BITS      = 16;

    // Frame counter width: it must hold 0..2*SLOT_BITS-1.
    function automatic int fc_width(input int slot_bits);
        return $clog2(2 * slot_bits);
    endfunction

    // IDLE   : nothing accepted since reset, counter parked at 0, line silent.
    // ARMING : first pair is pending; next edge loads it and opens frame 0.
    // RUN    : frame counter free-running, loads on every frame wrap.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMING = 2'd1,
        ST_RUN    = 2'd2
    } tx_state_e;

endpackage

// File: rtl/pcm_to_i2s_slot_serializer.sv
// i2s_slot_serializer: parallel-load, MSB-first, zero-fill shift register
// feeding one I2S slot (one instance per channel).
module i2s_slot_serializer
    import pcm_to_i2s_pkg::*;
#(
    parameter int NUMBER_OF_BITS = DEF_NUMBER_OF_BITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_load,
    input  logic [NUMBER_OF_BITS-1:0] i_data,
    input  logic                      i_shift,
    output logic                      o_msb
);

    logic [NUMBER_OF_BITS-1:0] r_sh;

    // Load a whole word, or move the next bit into the MSB position.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh <= '0;
        end else if (i_load) begin
            r_sh <= i_data;
        end else if (i_shift) begin
            r_sh <= {r_sh[NUMBER_OF_BITS-2:0], 1'b0};
        end
    end

    assign o_msb = r_sh[NUMBER_OF_BITS-1];

endmodule

// File: rtl/pcm_to_i2s.sv
// pcm_to_i2s: stereo PCM to standard I2S transmitter. One pair is accepted
// per frame through a single holding register; words go out MSB-first one
// bit clock after each ws edge.
// Build option PCM_TO_I2S_UNDERFLOW_HOLD_EN: when defined, an underflowing
// frame repeats the last transmitted pair; otherwise it transmits silence.
module pcm_to_i2s
    import pcm_to_i2s_pkg::*;
#(
    parameter int NUMBER_OF_BITS = DEF_NUMBER_OF_BITS,
    parameter int SLOT_BITS      = DEF_SLOT_BITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUMBER_OF_BITS-1:0] pcm_left,
    input  logic [NUMBER_OF_BITS-1:0] pcm_right,
    input  logic                      pcm_valid,
    output logic                      pcm_ready,
    output logic                      ws_out,
    output logic                      sd_out,
    output logic                      frame_start,
    output logic                      underflow
);

    localparam int FCW = fc_width(SLOT_BITS);
    typedef logic [FCW-1:0] fc_t;

    localparam fc_t FC_LAST    = fc_t'(2 * SLOT_BITS - 1);
    localparam fc_t FC_RSLOT   = fc_t'(SLOT_BITS);
    localparam fc_t FC_L_FIRST = fc_t'(1);
    localparam fc_t FC_L_LAST  = fc_t'(NUMBER_OF_BITS);
    localparam fc_t FC_R_FIRST = fc_t'(SLOT_BITS + 1);
    localparam fc_t FC_R_LAST  = fc_t'(SLOT_BITS + NUMBER_OF_BITS);

    tx_state_e r_state, w_state_next;

    fc_t                       r_fc;
    logic                      r_pending;
    logic                      r_ready;
    logic [NUMBER_OF_BITS-1:0] r_hold_l;
    logic [NUMBER_OF_BITS-1:0] r_hold_r;
    logic                      r_ws;
    logic                      r_sd;
    logic                      r_frame_start;
    logic                      r_underflow;

    logic                      w_accept;
    logic                      w_arm_load;
    logic                      w_load;
    fc_t                       w_fc_next;
    logic                      w_pending_next;
    logic                      w_left_win;
    logic                      w_right_win;
    logic                      w_sd_next;
    logic                      w_left_msb;
    logic                      w_right_msb;
    logic [NUMBER_OF_BITS-1:0] w_fill_l;
    logic [NUMBER_OF_BITS-1:0] w_fill_r;
    logic [NUMBER_OF_BITS-1:0] w_load_l;
    logic [NUMBER_OF_BITS-1:0] w_load_r;

    assign w_accept = pcm_valid && r_ready;

    // Arming state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Arming sequence: the first accept arms, the following edge performs
    // the arming load and starts the frame counter.
    always_comb begin
        w_state_next = r_state;
        w_arm_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_ARMING;
                end
            end
            ST_ARMING: begin
                w_arm_load   = 1'b1;
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // A load always lands the counter on fc=0, so the arming load behaves
    // exactly like a frame wrap.
    assign w_load    = w_arm_load || ((r_state == ST_RUN) && (r_fc == FC_LAST));
    assign w_fc_next = ((r_state == ST_RUN) && !w_load) ? r_fc + fc_t'(1) : '0;

    // An accept coinciding with a load only happens with pending clear, so
    // the new pair stays pending for the following frame.
    always_comb begin
        w_pending_next = r_pending;
        if (w_load) begin
            w_pending_next = 1'b0;
        end
        if (w_accept) begin
            w_pending_next = 1'b1;
        end
    end

    // Underflow fill source.
`ifdef PCM_TO_I2S_UNDERFLOW_HOLD_EN
    logic [NUMBER_OF_BITS-1:0] r_last_l;
    logic [NUMBER_OF_BITS-1:0] r_last_r;

    // Remember whatever was loaded last so an underflow repeats it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_l <= '0;
            r_last_r <= '0;
        end else if (w_load) begin
            r_last_l <= w_load_l;
            r_last_r <= w_load_r;
        end
    end

    assign w_fill_l = r_last_l;
    assign w_fill_r = r_last_r;
`else
    assign w_fill_l = '0;
    assign w_fill_r = '0;
`endif

    assign w_load_l = r_pending ? r_hold_l : w_fill_l;
    assign w_load_r = r_pending ? r_hold_r : w_fill_r;

    // Data windows are evaluated on the next counter value because sd_out
    // is registered: the bit appears in the cycle whose fc matches.
    assign w_left_win  = (w_fc_next >= FC_L_FIRST) && (w_fc_next <= FC_L_LAST);
    assign w_right_win = (w_fc_next >= FC_R_FIRST) && (w_fc_next <= FC_R_LAST);

    always_comb begin
        w_sd_next = 1'b0;
        if (w_left_win) begin
            w_sd_next = w_left_msb;
        end else if (w_right_win) begin
            w_sd_next = w_right_msb;
        end
    end

    i2s_slot_serializer #(
        .NUMBER_OF_BITS(NUMBER_OF_BITS)
    ) u_ser_left (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_data (w_load_l),
        .i_shift(w_left_win),
        .o_msb  (w_left_msb)
    );

    i2s_slot_serializer #(
        .NUMBER_OF_BITS(NUMBER_OF_BITS)
    ) u_ser_right (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_load),
        .i_data (w_load_r),
        .i_shift(w_right_win),
        .o_msb  (w_right_msb)
    );

    // Frame counter, handshake, holding register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fc          <= '0;
            r_pending     <= 1'b0;
            r_ready       <= 1'b1;
            r_hold_l      <= '0;
            r_hold_r      <= '0;
            r_ws          <= 1'b0;
            r_sd          <= 1'b0;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_fc          <= w_fc_next;
            r_pending     <= w_pending_next;
            r_ready       <= !w_pending_next;
            r_ws          <= (w_fc_next >= FC_RSLOT);
            r_sd          <= w_sd_next;
            r_frame_start <= w_load;
            if (w_accept) begin
                r_hold_l <= pcm_left;
                r_hold_r <= pcm_right;
            end
            if (w_load && !r_pending) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign pcm_ready   = r_ready;
    assign ws_out      = r_ws;
    assign sd_out      = r_sd;
    assign frame_start = r_frame_start;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_pcm_to_i2s.sv
// tb_pcm_to_i2s: directed bench for pcm_to_i2s at NUMBER_OF_BITS=8,
// SLOT_BITS=16. Frames are captured one sample per fc into 32-bit vectors
// (bit i = value while fc==i) and compared against hand-built expectations.
module tb_pcm_to_i2s;

    logic       clk;
    logic       reset;
    logic [7:0] pcm_left;
    logic [7:0] pcm_right;
    logic       pcm_valid;
    logic       pcm_ready;
    logic       ws_out;
    logic       sd_out;
    logic       frame_start;
    logic       underflow;

    int n_chk;
    int n_err;

    pcm_to_i2s #(
        .NUMBER_OF_BITS(8),
        .SLOT_BITS     (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pcm_left   (pcm_left),
        .pcm_right  (pcm_right),
        .pcm_valid  (pcm_valid),
        .pcm_ready  (pcm_ready),
        .ws_out     (ws_out),
        .sd_out     (sd_out),
        .frame_start(frame_start),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected sd vector: left bits MSB-first at fc=1..8, right at fc=17..24.
    function automatic logic [31:0] exp_sd(input logic [7:0] l, input logic [7:0] r);
        logic [31:0] e;
        e = '0;
        for (int k = 0; k < 8; k++) begin
            e[1 + k]  = l[7 - k];
            e[17 + k] = r[7 - k];
        end
        return e;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Hand one pair to an idle transmitter and step through the arming load.
    task automatic arm(input logic [7:0] l, input logic [7:0] r);
        pcm_left  = l;
        pcm_right = r;
        pcm_valid = 1'b1;
        tick();
        pcm_valid = 1'b0;
        chk("arm_ready_low", 32'(pcm_ready), 32'd0);
        tick();
    endtask

    // Capture one frame starting at fc=0; optionally offer a pair at fc=send_at.
    task automatic check_frame(input string tag, input logic [31:0] e_sd,
                               input logic [31:0] e_rdy, input logic e_uf,
                               input int send_at, input logic [7:0] nl,
                               input logic [7:0] nr);
        logic [31:0] g_sd, g_ws, g_fs, g_rdy;
        logic        g_uf;
        g_uf = underflow;
        for (int i = 0; i < 32; i++) begin
            g_sd[i]  = sd_out;
            g_ws[i]  = ws_out;
            g_fs[i]  = frame_start;
            g_rdy[i] = pcm_ready;
            if (i == send_at) begin
                pcm_left  = nl;
                pcm_right = nr;
                pcm_valid = 1'b1;
            end
            tick();
            pcm_valid = 1'b0;
        end
        chk({tag, "_sd"}, g_sd, e_sd);
        chk({tag, "_ws"}, g_ws, 32'hFFFF0000);
        chk({tag, "_fs"}, g_fs, 32'h00000001);
        chk({tag, "_rdy"}, g_rdy, e_rdy);
        chk({tag, "_uf"}, 32'(g_uf), 32'(e_uf));
    endtask

    int fs_cnt;
    int sd_cnt;

    initial begin
        n_chk     = 0;
        n_err     = 0;
        reset     = 1'b1;
        pcm_left  = '0;
        pcm_right = '0;
        pcm_valid = 1'b0;

        // Reset state and idle line.
        tick();
        chk("rst_ws", 32'(ws_out), 32'd0);
        chk("rst_sd", 32'(sd_out), 32'd0);
        chk("rst_ready", 32'(pcm_ready), 32'd1);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_uf", 32'(underflow), 32'd0);
        tick();
        reset  = 1'b0;
        fs_cnt = 0;
        sd_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            fs_cnt += int'(frame_start);
            sd_cnt += int'(sd_out) + int'(ws_out);
        end
        chk("idle_fs", 32'(fs_cnt), 32'd0);
        chk("idle_sd_ws", 32'(sd_cnt), 32'd0);
        chk("idle_ready", 32'(pcm_ready), 32'd1);
        chk("idle_uf", 32'(underflow), 32'd0);

        // Single pair A5/3C: bits at fc 1,3,6,8 and 19..22.
        arm(8'hA5, 8'h3C);
        check_frame("single", 32'h0078014A, 32'hFFFFFFFF, 1'b0, -1, 8'h00, 8'h00);
        chk("single_next_uf", 32'(underflow), 32'd1);

        // Four pairs back-to-back, then starvation.
        do_reset();
        arm(8'h12, 8'h34);
        check_frame("s0", exp_sd(8'h12, 8'h34), 32'h0000000F, 1'b0, 3, 8'hC3, 8'h5A);
        check_frame("s1", exp_sd(8'hC3, 8'h5A), 32'h0000000F, 1'b0, 3, 8'h01, 8'h80);
        check_frame("s2", exp_sd(8'h01, 8'h80), 32'h0000000F, 1'b0, 3, 8'h7F, 8'h80);
        check_frame("s3", exp_sd(8'h7F, 8'h80), 32'hFFFFFFFF, 1'b0, -1, 8'h00, 8'h00);
`ifdef PCM_TO_I2S_UNDERFLOW_HOLD_EN
        check_frame("s4_under", exp_sd(8'h7F, 8'h80), 32'hFFFFFFFF, 1'b1, -1, 8'h00, 8'h00);
`else
        check_frame("s4_under", 32'h00000000, 32'hFFFFFFFF, 1'b1, -1, 8'h00, 8'h00);
`endif

        // Pair offered exactly at fc=31 with nothing pending.
        do_reset();
        arm(8'h55, 8'hAA);
        check_frame("late0", exp_sd(8'h55, 8'hAA), 32'hFFFFFFFF, 1'b0, 31, 8'h96, 8'h69);
`ifdef PCM_TO_I2S_UNDERFLOW_HOLD_EN
        check_frame("late1", exp_sd(8'h55, 8'hAA), 32'h00000000, 1'b1, -1, 8'h00, 8'h00);
`else
        check_frame("late1", 32'h00000000, 32'h00000000, 1'b1, -1, 8'h00, 8'h00);
`endif
        check_frame("late2", exp_sd(8'h96, 8'h69), 32'hFFFFFFFF, 1'b1, -1, 8'h00, 8'h00);

        // Reset in the middle of the right slot with a pair pending.
        do_reset();
        arm(8'hE7, 8'h18);
        for (int i = 0; i < 20; i++) begin
            if (i == 3) begin
                pcm_left  = 8'h11;
                pcm_right = 8'h22;
                pcm_valid = 1'b1;
            end
            tick();
            pcm_valid = 1'b0;
        end
        chk("mid_ws", 32'(ws_out), 32'd1);
        chk("mid_pending", 32'(pcm_ready), 32'd0);
        reset = 1'b1;
        tick();
        chk("mrst_ws", 32'(ws_out), 32'd0);
        chk("mrst_sd", 32'(sd_out), 32'd0);
        chk("mrst_ready", 32'(pcm_ready), 32'd1);
        chk("mrst_fs", 32'(frame_start), 32'd0);
        chk("mrst_uf", 32'(underflow), 32'd0);
        reset  = 1'b0;
        fs_cnt = 0;
        sd_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            fs_cnt += int'(frame_start);
            sd_cnt += int'(sd_out) + int'(ws_out);
        end
        chk("post_fs", 32'(fs_cnt), 32'd0);
        chk("post_sd_ws", 32'(sd_cnt), 32'd0);
        chk("post_ready", 32'(pcm_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
